alu_frame_ctrl: RTL and testbench

ALU_FRAME_CTRL -- requirements
Module: alu_frame_ctrl

---
 rtl/alu_frame_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_alu_frame_ctrl.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_frame_ctrl.sv
// alu_frame_ctrl: receives 5-byte command frames (A5, OPC, A, B, CHK) from a
// UART RX FIFO, drives registered operands into an external combinational ALU
// and writes a two-byte response (header, payload) into the UART TX FIFO.
module alu_frame_ctrl #(
    parameter int BUS_SIZE = 8,
    parameter int OP_W     = 6,
    parameter int TIMEOUT  = 50_000_000,
    parameter int TO_BITS  = 26
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                rx_empty,
    input  logic [BUS_SIZE-1:0] r_data,
    output logic                rd_uart,
    input  logic                tx_full,
    output logic [BUS_SIZE-1:0] w_data,
    output logic                wr_uart,
    output logic [BUS_SIZE-1:0] op_a,
    output logic [BUS_SIZE-1:0] op_b,
    output logic [OP_W-1:0]     op_code,
    input  logic [BUS_SIZE-1:0] alu_result,
    output logic                busy,
    output logic [7:0]          err_cnt
);

    localparam logic [BUS_SIZE-1:0] SYNC_BYTE = BUS_SIZE'(8'hA5);
    localparam logic [BUS_SIZE-1:0] HDR_OK    = BUS_SIZE'(8'h5A);
    localparam logic [BUS_SIZE-1:0] HDR_ERR   = BUS_SIZE'(8'hEE);
    localparam logic [BUS_SIZE-1:0] CODE_OPC  = BUS_SIZE'(8'h01);
    localparam logic [BUS_SIZE-1:0] CODE_CHK  = BUS_SIZE'(8'h02);
    localparam logic [TO_BITS-1:0]  TO_LAST   = TO_BITS'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        GET_OP,
        GET_A,
        GET_B,
        GET_CHK,
        EXEC,
        SEND_HDR,
        SEND_RES
    } state_t;

    state_t               r_state;
    state_t               w_next;

    logic [BUS_SIZE-1:0]  r_opc;
    logic [BUS_SIZE-1:0]  r_a;
    logic [BUS_SIZE-1:0]  r_b;
    logic [BUS_SIZE-1:0]  r_op_a;
    logic [BUS_SIZE-1:0]  r_op_b;
    logic [OP_W-1:0]      r_op_code;
    logic [BUS_SIZE-1:0]  r_tx_hdr;
    logic [BUS_SIZE-1:0]  r_tx_res;
    logic [TO_BITS-1:0]   r_to_cnt;
    logic [7:0]           r_err_cnt;

    logic                 w_pop;
    logic                 w_in_get;
    logic                 w_timeout;
    logic                 w_chk_ok;
    logic                 w_opc_ok;
    logic                 w_chk_pop;
    logic                 w_err_inc;

    assign w_pop     = rd_uart;
    assign w_in_get  = (r_state == GET_OP) || (r_state == GET_A) ||
                       (r_state == GET_B)  || (r_state == GET_CHK);
    assign w_timeout = w_in_get && rx_empty && (r_to_cnt == TO_LAST);
    assign w_chk_ok  = (r_data == (r_opc ^ r_a ^ r_b));
    assign w_opc_ok  = (r_opc[BUS_SIZE-1:OP_W] == '0);
    assign w_chk_pop = (r_state == GET_CHK) && w_pop;
    assign w_err_inc = w_timeout || (w_chk_pop && !(w_chk_ok && w_opc_ok));

    assign op_a    = r_op_a;
    assign op_b    = r_op_b;
    assign op_code = r_op_code;
    assign err_cnt = r_err_cnt;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic: a pop always wins over a timeout in the same cycle
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_pop && (r_data == SYNC_BYTE)) w_next = GET_OP;
            end
            GET_OP: begin
                if (w_pop)          w_next = GET_A;
                else if (w_timeout) w_next = IDLE;
            end
            GET_A: begin
                if (w_pop)          w_next = GET_B;
                else if (w_timeout) w_next = IDLE;
            end
            GET_B: begin
                if (w_pop)          w_next = GET_CHK;
                else if (w_timeout) w_next = IDLE;
            end
            GET_CHK: begin
                if (w_pop)          w_next = (w_chk_ok && w_opc_ok) ? EXEC : SEND_HDR;
                else if (w_timeout) w_next = IDLE;
            end
            EXEC: begin
                w_next = SEND_HDR;
            end
            SEND_HDR: begin
                if (!tx_full) w_next = SEND_RES;
            end
            SEND_RES: begin
                if (!tx_full) w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Output decode; FIFO strobes are masked during reset so no byte moves
    always_comb begin
        rd_uart = 1'b0;
        wr_uart = 1'b0;
        w_data  = '0;
        busy    = (r_state != IDLE);
        case (r_state)
            IDLE, GET_OP, GET_A, GET_B, GET_CHK: begin
                rd_uart = !reset && !rx_empty;
            end
            SEND_HDR: begin
                wr_uart = !reset && !tx_full;
                w_data  = r_tx_hdr;
            end
            SEND_RES: begin
                wr_uart = !reset && !tx_full;
                w_data  = r_tx_res;
            end
            default: begin
                rd_uart = 1'b0;
            end
        endcase
    end

    // Datapath: shadow capture, operand load, response bytes, timeout, errors
    always_ff @(posedge clk) begin
        if (reset) begin
            r_opc     <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_op_a    <= '0;
            r_op_b    <= '0;
            r_op_code <= '0;
            r_tx_hdr  <= '0;
            r_tx_res  <= '0;
            r_to_cnt  <= '0;
            r_err_cnt <= '0;
        end else begin
            if (w_pop || !w_in_get || w_timeout) begin
                r_to_cnt <= '0;
            end else begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end

            if (w_pop && (r_state == GET_OP)) r_opc <= r_data;
            if (w_pop && (r_state == GET_A))  r_a   <= r_data;
            if (w_pop && (r_state == GET_B))  r_b   <= r_data;

            if (w_chk_pop) begin
                if (!w_chk_ok) begin
                    r_tx_hdr <= HDR_ERR;
                    r_tx_res <= CODE_CHK;
                end else if (!w_opc_ok) begin
                    r_tx_hdr <= HDR_ERR;
                    r_tx_res <= CODE_OPC;
                end else begin
                    r_tx_hdr  <= HDR_OK;
                    r_op_code <= r_opc[OP_W-1:0];
                    r_op_a    <= r_a;
                    r_op_b    <= r_b;
                end
            end

            if (r_state == EXEC) r_tx_res <= alu_result;

            if (w_err_inc && (r_err_cnt != 8'hFF)) r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_alu_frame_ctrl.sv
// Directed bench for alu_frame_ctrl: FIFO models around the DUT, a small ALU,
// a table of frames with hand-computed responses, and sequences for timeout,
// TX back-pressure, garbage bytes, mid-frame reset and error saturation.
module tb_alu_frame_ctrl;

    localparam int BW  = 8;
    localparam int OW  = 6;
    localparam int TO  = 20;
    localparam int TOB = 8;
    localparam int DEPTH = 4096;

    logic          clk = 1'b0;
    logic          reset;
    logic          rx_empty;
    logic [BW-1:0] r_data;
    logic          rd_uart;
    logic          tx_full;
    logic [BW-1:0] w_data;
    logic          wr_uart;
    logic [BW-1:0] op_a;
    logic [BW-1:0] op_b;
    logic [OW-1:0] op_code;
    logic [BW-1:0] alu_result;
    logic          busy;
    logic [7:0]    err_cnt;

    alu_frame_ctrl #(
        .BUS_SIZE (BW),
        .OP_W     (OW),
        .TIMEOUT  (TO),
        .TO_BITS  (TOB)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_empty   (rx_empty),
        .r_data     (r_data),
        .rd_uart    (rd_uart),
        .tx_full    (tx_full),
        .w_data     (w_data),
        .wr_uart    (wr_uart),
        .op_a       (op_a),
        .op_b       (op_b),
        .op_code    (op_code),
        .alu_result (alu_result),
        .busy       (busy),
        .err_cnt    (err_cnt)
    );

    always #5 clk = ~clk;

    // Reference ALU: 1 = ADD, 2 = SUB, anything else = XOR
    always_comb begin
        case (op_code)
            6'd1:    alu_result = op_a + op_b;
            6'd2:    alu_result = op_a - op_b;
            default: alu_result = op_a ^ op_b;
        endcase
    end

    // FIFO models: the initial block writes rx_buf/rx_wr, the monitor owns the rest
    logic [7:0] rx_buf [DEPTH];
    int         rx_wr = 0;
    int         rx_rd = 0;
    int         pop_cyc [DEPTH];
    logic [7:0] tx_buf [DEPTH];
    int         tx_cyc [DEPTH];
    int         tx_cnt = 0;
    int         cyc = 0;
    int         viol = 0;

    assign rx_empty = (rx_rd == rx_wr);
    assign r_data   = rx_buf[rx_rd];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rd_uart) begin
            if (rx_empty) viol <= viol + 1;
            pop_cyc[rx_rd] <= cyc;
            rx_rd <= rx_rd + 1;
        end
        if (wr_uart) begin
            if (tx_full) viol <= viol + 1;
            tx_buf[tx_cnt] <= w_data;
            tx_cyc[tx_cnt] <= cyc;
            tx_cnt <= tx_cnt + 1;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        rx_buf[rx_wr] = b;
        rx_wr = rx_wr + 1;
    endtask

    task automatic push_frame(input logic [39:0] f);
        for (int unsigned i = 0; i < 5; i++) push(f[39-8*i -: 8]);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Wait for n response bytes past base, then for the controller to idle
    task automatic wait_tx(input int base, input int n, input bit report);
        int k;
        k = 0;
        while (((tx_cnt - base) < n) && (k < 300)) begin
            @(negedge clk);
            k++;
        end
        k = 0;
        while (busy && (k < 300)) begin
            @(negedge clk);
            k++;
        end
        tick(4);
        if (report) begin
            chk("tx_count", tx_cnt - base, n);
            chk("busy_after", int'(busy), 0);
        end
    endtask

    typedef struct {
        logic [39:0] frame;
        logic [7:0]  hdr;
        logic [7:0]  res;
        bit          load;
        int          lat;
    } vec_t;

    vec_t vecs [7];

    logic [7:0] m_opc, m_a, m_b;
    int         err_exp;
    int         base;
    int         rx_base;

    initial begin
        vecs[0] = '{40'hA5_01_03_04_06, 8'h5A, 8'h07, 1'b1, 2};
        vecs[1] = '{40'hA5_01_03_04_07, 8'hEE, 8'h02, 1'b0, 1};
        vecs[2] = '{40'hA5_41_03_04_46, 8'hEE, 8'h01, 1'b0, 1};
        vecs[3] = '{40'hA5_C1_00_00_00, 8'hEE, 8'h02, 1'b0, 1};
        vecs[4] = '{40'hA5_02_09_05_0E, 8'h5A, 8'h04, 1'b1, 2};
        vecs[5] = '{40'hA5_3F_FF_0F_CF, 8'h5A, 8'hF0, 1'b1, 2};
        vecs[6] = '{40'hA5_01_FF_01_FF, 8'h5A, 8'h00, 1'b1, 2};

        reset   = 1'b1;
        tx_full = 1'b0;
        m_opc   = 8'h00;
        m_a     = 8'h00;
        m_b     = 8'h00;
        err_exp = 0;

        // Reset state
        tick(3);
        chk("rst_busy", int'(busy), 0);
        chk("rst_rd", int'(rd_uart), 0);
        chk("rst_wr", int'(wr_uart), 0);
        chk("rst_wdata", int'(w_data), 0);
        chk("rst_ops", int'({op_code, op_a, op_b}), 0);
        chk("rst_err", int'(err_cnt), 0);
        reset = 1'b0;
        tick(2);

        // Table-driven frames
        for (int i = 0; i < 7; i++) begin
            base    = tx_cnt;
            rx_base = rx_wr;
            push_frame(vecs[i].frame);
            wait_tx(base, 2, 1'b1);
            if (vecs[i].load) begin
                m_opc = vecs[i].frame[31:24];
                m_a   = vecs[i].frame[23:16];
                m_b   = vecs[i].frame[15:8];
            end else begin
                err_exp++;
            end
            chk($sformatf("v%0d_hdr", i), int'(tx_buf[base]), int'(vecs[i].hdr));
            chk($sformatf("v%0d_res", i), int'(tx_buf[base+1]), int'(vecs[i].res));
            chk($sformatf("v%0d_lat", i), tx_cyc[base] - pop_cyc[rx_base+4], vecs[i].lat);
            chk($sformatf("v%0d_res_gap", i), tx_cyc[base+1] - tx_cyc[base], 1);
            chk($sformatf("v%0d_opcode", i), int'(op_code), int'(m_opc[5:0]));
            chk($sformatf("v%0d_opa", i), int'(op_a), int'(m_a));
            chk($sformatf("v%0d_opb", i), int'(op_b), int'(m_b));
            chk($sformatf("v%0d_err", i), int'(err_cnt), err_exp);
        end

        // Timeout after A5 01, then a normal frame
        base = tx_cnt;
        push(8'hA5);
        push(8'h01);
        tick(6);
        chk("to_busy_early", int'(busy), 1);
        tick(TO + 2);
        chk("to_busy_fall", int'(busy), 0);
        chk("to_no_tx", tx_cnt - base, 0);
        err_exp++;
        chk("to_err", int'(err_cnt), err_exp);
        push_frame(40'hA5_01_03_04_06);
        wait_tx(base, 2, 1'b1);
        m_opc = 8'h01; m_a = 8'h03; m_b = 8'h04;
        chk("to_next_hdr", int'(tx_buf[base]), 8'h5A);
        chk("to_next_res", int'(tx_buf[base+1]), 8'h07);

        // TX back-pressure held well past the end of the frame
        base = tx_cnt;
        tx_full = 1'b1;
        push_frame(40'hA5_02_09_05_0E);
        tick(15);
        chk("bp_no_tx", tx_cnt - base, 0);
        chk("bp_wr", int'(wr_uart), 0);
        chk("bp_busy", int'(busy), 1);
        chk("bp_wdata_held", int'(w_data), 8'h5A);
        tx_full = 1'b0;
        wait_tx(base, 2, 1'b1);
        m_opc = 8'h02; m_a = 8'h09; m_b = 8'h05;
        chk("bp_hdr", int'(tx_buf[base]), 8'h5A);
        chk("bp_res", int'(tx_buf[base+1]), 8'h04);

        // Leading garbage; operands must stay put until the checksum arrives
        base = tx_cnt;
        push(8'h00);
        push(8'hA5);
        push(8'h01);
        push(8'h10);
        push(8'h20);
        tick(10);
        chk("gb_err_keep", int'(err_cnt), err_exp);
        chk("gb_opa_hold", int'(op_a), int'(m_a));
        chk("gb_opb_hold", int'(op_b), int'(m_b));
        chk("gb_opc_hold", int'(op_code), int'(m_opc[5:0]));
        push(8'h31);
        wait_tx(base, 2, 1'b1);
        chk("gb_hdr", int'(tx_buf[base]), 8'h5A);
        chk("gb_res", int'(tx_buf[base+1]), 8'h30);
        chk("gb_opa", int'(op_a), 8'h10);
        chk("gb_err", int'(err_cnt), err_exp);

        // Reset after A5 01; third byte must remain in the RX FIFO
        base = tx_cnt;
        push(8'hA5);
        push(8'h01);
        push(8'h03);
        tick(2);
        reset = 1'b1;
        tick(2);
        chk("mr_busy", int'(busy), 0);
        chk("mr_rd", int'(rd_uart), 0);
        chk("mr_wr", int'(wr_uart), 0);
        chk("mr_ops", int'({op_code, op_a, op_b}), 0);
        chk("mr_err", int'(err_cnt), 0);
        chk("mr_fifo_left", rx_wr - rx_rd, 1);
        reset = 1'b0;
        tick(TO + 5);
        chk("mr_no_tx", tx_cnt - base, 0);
        chk("mr_err_after", int'(err_cnt), 0);

        // Error counter saturation
        for (int i = 0; i < 260; i++) begin
            base = tx_cnt;
            push_frame(40'hA5_00_00_00_01);
            wait_tx(base, 2, 1'b0);
        end
        chk("sat_err", int'(err_cnt), 8'hFF);
        chk("sat_hdr", int'(tx_buf[tx_cnt-2]), 8'hEE);

        chk("fifo_protocol", viol, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
